// File: rtl/alu_mul_div_seq.sv
// Sequential signed multiply/divide: radix-2 Booth multiplier and restoring divider, 33-cycle latency.
// Define ALU_MUL_DIV_DIVIDE_EN to build the divider; otherwise op=1 handshakes and returns zero.
module alu_mul_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_done, r_op, r_qm1;
  logic [WIDTH:0]   r_acc_hi;   // Booth A (one guard bit) or divider remainder
  logic [WIDTH-1:0] r_acc_lo;   // Booth Q or divider quotient
  logic [WIDTH:0]   r_m;        // sign-extended multiplicand or zero-extended |divisor|
  logic [WIDTH-1:0] r_hi, r_lo;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_acc_hi_nxt;
  logic [WIDTH-1:0] w_acc_lo_nxt;
  logic             w_qm1_nxt;
  logic [WIDTH-1:0] w_hi_res, w_lo_res;

`ifdef ALU_MUL_DIV_DIVIDE_EN
  logic [WIDTH-1:0] r_a;
  logic             r_b_neg, r_dz;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH+1:0] w_div_trial;

  assign w_a_mag     = a[WIDTH-1] ? -a : a;
  assign w_b_mag     = b[WIDTH-1] ? -b : b;
  assign w_div_shift = {r_acc_hi[WIDTH-1:0], r_acc_lo[WIDTH-1]};
  assign w_div_trial = {1'b0, w_div_shift} - {1'b0, r_m};
`endif

  always_comb begin
    case ({r_acc_lo[0], r_qm1})
      2'b01:   w_mul_sum = r_acc_hi + r_m;
      2'b10:   w_mul_sum = r_acc_hi - r_m;
      default: w_mul_sum = r_acc_hi;
    endcase
  end

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_acc_hi_nxt = {w_mul_sum[WIDTH], w_mul_sum[WIDTH:1]};
    w_acc_lo_nxt = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
    w_qm1_nxt    = r_acc_lo[0];
`ifdef ALU_MUL_DIV_DIVIDE_EN
    if (r_op) begin
      // Keep the trial difference only when it did not go negative (restoring step).
      w_acc_hi_nxt = w_div_trial[WIDTH+1] ? w_div_shift : w_div_trial[WIDTH:0];
      w_acc_lo_nxt = {r_acc_lo[WIDTH-2:0], ~w_div_trial[WIDTH+1]};
    end
`endif
  end

  always_comb begin
    w_hi_res = r_acc_hi[WIDTH-1:0];
    w_lo_res = r_acc_lo;
`ifdef ALU_MUL_DIV_DIVIDE_EN
    if (r_op) begin
      if (r_dz) begin
        w_lo_res = '1;
        w_hi_res = r_a;
      end else begin
        w_lo_res = (r_a[WIDTH-1] ^ r_b_neg) ? -r_acc_lo : r_acc_lo;
        w_hi_res = r_a[WIDTH-1] ? -r_acc_hi[WIDTH-1:0] : r_acc_hi[WIDTH-1:0];
      end
    end
`else
    if (r_op) begin
      w_hi_res = '0;
      w_lo_res = '0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_op     <= 1'b0;
      r_qm1    <= 1'b0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_m      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
`ifdef ALU_MUL_DIV_DIVIDE_EN
      r_a      <= '0;
      r_b_neg  <= 1'b0;
      r_dz     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_op     <= op;
            r_qm1    <= 1'b0;
            r_acc_hi <= '0;
`ifdef ALU_MUL_DIV_DIVIDE_EN
            r_a      <= a;
            r_b_neg  <= b[WIDTH-1];
            r_dz     <= op && (b == '0);
            if (op) begin
              r_acc_lo <= w_a_mag;
              r_m      <= {1'b0, w_b_mag};
            end else begin
              r_acc_lo <= b;
              r_m      <= {a[WIDTH-1], a};
            end
`else
            r_acc_lo <= b;
            r_m      <= {a[WIDTH-1], a};
`endif
          end
        end
        S_RUN: begin
          r_cnt    <= r_cnt + 1'b1;
          r_acc_hi <= w_acc_hi_nxt;
          r_acc_lo <= w_acc_lo_nxt;
          r_qm1    <= w_qm1_nxt;
          if (r_cnt == LAST) r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_hi    <= w_hi_res;
          r_lo    <= w_lo_res;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_alu_mul_div_seq.sv
// Scoreboard bench for alu_mul_div_seq: driver pushes expected results, a negedge monitor pops on done.
// Expected divide results follow ALU_MUL_DIV_DIVIDE_EN, matching how the design is built.
module tb_alu_mul_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic        op, start;
  logic        busy, done;
  logic [31:0] hi, lo;

  alu_mul_div_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .start(start),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] exp;
    int          done_cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] last_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic o);
    longint sx, sy, p, q, r;
    logic [63:0] pv, qv, rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o) begin
      p  = sx * sy;
      pv = p;
      return pv;
    end
`ifdef ALU_MUL_DIV_DIVIDE_EN
    if (y == 32'h0) return {x, 32'hFFFF_FFFF};
    q  = sx / sy;
    r  = sx % sy;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
`else
    return 64'h0;
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, {hi, lo}, e.exp);
        check({e.name, "_latency"}, 64'(cyc), 64'(e.done_cyc));
        last_res = e.exp;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got %0d pending results, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic push(input logic [31:0] x, input logic [31:0] y, input logic o,
                      input int dcyc, input string name);
    exp_t e;
    e.exp      = model(x, y, o);
    e.done_cyc = dcyc;
    e.name     = name;
    sb.push_back(e);
  endtask

  // Single operation: hold check on idle outputs, then a one-cycle start pulse.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic o, input string name);
    check({name, "_hold"}, {hi, lo}, last_res);
    a = x; b = y; op = o; start = 1'b1;
    push(x, y, o, cyc + 34, name);
    step();
    start = 1'b0;
    a = ~x; b = ~y; op = ~o;
    check({name, "_busy"}, 64'(busy), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; op = 1'b0;
    repeat (3) step();
    check("reset_state", {28'h0, busy, done, 2'b00, hi, lo}, 64'h0);
    reset = 1'b0;
    step();

    issue(32'h7C, 32'h7, 1'b0, "mul_7c_7");
    wait_idle("mul_7c_7");
    issue(32'hFFFF_FFFD, 32'h5, 1'b0, "mul_neg3_5");
    wait_idle("mul_neg3_5");
    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, "mul_max");
    wait_idle("mul_max");
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, "mul_min");
    wait_idle("mul_min");
    issue(32'hFFFF_FFF9, 32'h2, 1'b1, "div_neg7_2");
    wait_idle("div_neg7_2");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
    wait_idle("div_ovf");
    issue(32'h1234, 32'h0, 1'b1, "div_zero");
    wait_idle("div_zero");
    issue(32'h64, 32'hFFFF_FFF9, 1'b1, "div_100_neg7");
    wait_idle("div_100_neg7");

    // A second start ten cycles into a run must be dropped.
    issue(32'h0001_2345, 32'hFFFF_0003, 1'b0, "ignored_start");
    repeat (9) step();
    a = 32'h55; b = 32'h66; op = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("ignored_start");
    repeat (40) step();

    // Start held high through done: second op is accepted in the done cycle.
    check("b2b_hold", {hi, lo}, last_res);
    a = 32'h0000_0BAD; b = 32'hFFFF_FF00; op = 1'b0; start = 1'b1;
    d = cyc + 34;
    push(32'h0000_0BAD, 32'hFFFF_FF00, 1'b0, d, "b2b_first");
    step();
    a = 32'hFFFF_FF9C; b = 32'h0000_0007; op = 1'b1;
    push(32'hFFFF_FF9C, 32'h0000_0007, 1'b1, d + 34, "b2b_second");
    d = 0;
    while (!done && d < 60) begin
      step();
      d++;
    end
    step();
    start = 1'b0;
    wait_idle("b2b");

    // Reset mid-operation aborts with no done pulse.
    issue(32'h0000_7777, 32'h0000_3333, 1'b0, "abort");
    repeat (14) step();
    reset = 1'b1;
    sb.delete();
    step();
    check("abort_reset_state", {28'h0, busy, done, 2'b00, hi, lo}, 64'h0);
    reset = 1'b0;
    last_res = '0;
    repeat (40) step();

    // Reset and start together: request dropped.
    reset = 1'b1; a = 32'h9; b = 32'h9; op = 1'b0; start = 1'b1;
    step();
    reset = 1'b0; start = 1'b0;
    step();
    check("reset_start_busy", 64'(busy), 64'd0);
    repeat (40) step();

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: rb = 32'h0;
        2: rb = 32'hFFFF_FFFF;
        3: begin ra = $urandom_range(0, 100); rb = $urandom_range(1, 9); end
        default: ;
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
      wait_idle("rand");
    end

    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
